// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of 64-byte store lines with youngest-entry merge, L2 req/ack drain, full back-pressure and load match
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         access_i,
  input  logic         write_i,
  input  logic [31:0]  address_i,
  input  logic [63:0]  mask_i,
  input  logic [511:0] data_i,
  output logic         full_o,
  output logic         load_match_o,
  output logic         l2_req_o,
  output logic [25:0]  l2_address_o,
  output logic [63:0]  l2_mask_o,
  output logic [511:0] l2_data_o,
  input  logic         l2_ack_i,
  output logic         store_complete_o
);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [25:0]      line_q [DEPTH];
  logic [25:0]      line_d [DEPTH];
  logic [63:0]      mask_q [DEPTH];
  logic [63:0]      mask_d [DEPTH];
  logic [511:0]     data_q [DEPTH];
  logic [511:0]     data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, last;
  logic [PTR_W:0]   count_q, count_d;
  logic             done_q, done_d;
  logic             st, merge, enq, deq, hit;
  assign full_o = count_q == (PTR_W+1)'(DEPTH);
  assign l2_req_o = count_q != '0;
  assign l2_address_o = line_q[head_q];
  assign l2_mask_o = mask_q[head_q];
  assign l2_data_o = data_q[head_q];
  assign store_complete_o = done_q;
  assign last = tail_q - 1'b1;
  assign st = access_i & write_i & ~full_o;
  assign merge = st & l2_req_o & (line_q[last] == address_i[31:6]) & ~((last == head_q) & l2_req_o);
  assign enq = st & ~merge;
  assign deq = l2_req_o & l2_ack_i;
  assign load_match_o = access_i & ~write_i & hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (valid_q[i] & (line_q[i] == address_i[31:6]));
  end
  always_comb begin
    valid_d = valid_q;
    line_d = line_q;
    mask_d = mask_q;
    data_d = data_q;
    head_d = deq ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
    done_d = deq;
    if (merge) begin
      mask_d[last] = mask_q[last] | mask_i;
      for (int b = 0; b < 64; b++) data_d[last][8*b +: 8] = mask_i[b] ? data_i[8*b +: 8] : data_q[last][8*b +: 8];
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      line_d[tail_q] = address_i[31:6];
      mask_d[tail_q] = mask_i;
      data_d[tail_q] = data_i;
    end
    if (deq) valid_d[head_q] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      done_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    line_q <= line_d;
    mask_q <= mask_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenario tasks with hand-computed expectations for store_buffer
module tb_store_buffer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         access_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  address_i = '0;
  logic [63:0]  mask_i = '0;
  logic [511:0] data_i = '0;
  logic         l2_ack_i = 1'b0;
  logic         full_o, load_match_o, l2_req_o, store_complete_o;
  logic [25:0]  l2_address_o;
  logic [63:0]  l2_mask_o;
  logic [511:0] l2_data_o;
  int vec = 0;
  int miss = 0;
  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .access_i(access_i), .write_i(write_i),
    .address_i(address_i), .mask_i(mask_i), .data_i(data_i),
    .full_o(full_o), .load_match_o(load_match_o), .l2_req_o(l2_req_o),
    .l2_address_o(l2_address_o), .l2_mask_o(l2_mask_o), .l2_data_o(l2_data_o),
    .l2_ack_i(l2_ack_i), .store_complete_o(store_complete_o)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic a, input logic w, input logic [31:0] ad, input logic [63:0] m, input logic [511:0] d, input logic k);
    access_i = a;
    write_i = w;
    address_i = ad;
    mask_i = m;
    data_i = d;
    l2_ack_i = k;
    #1;
  endtask
  task automatic idle;
    drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    do_reset();
    vec++; if (full_o !== 1'b0) begin miss++; $display("FAIL reset_full: got %0b want 0", full_o); end
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL reset_req: got %0b want 0", l2_req_o); end
    vec++; if (load_match_o !== 1'b0) begin miss++; $display("FAIL reset_lm: got %0b want 0", load_match_o); end
    vec++; if (store_complete_o !== 1'b0) begin miss++; $display("FAIL reset_sc: got %0b want 0", store_complete_o); end
  endtask
  task automatic test_single;
    do_reset();
    drv(1'b1, 1'b1, 32'h1000, 64'hF, 512'hDEADBEEF, 1'b0);
    cyc();
    idle();
    vec++; if (l2_req_o !== 1'b1) begin miss++; $display("FAIL single_req: got %0b want 1", l2_req_o); end
    vec++; if (l2_address_o !== 26'h40) begin miss++; $display("FAIL single_addr: got %h want 40", l2_address_o); end
    vec++; if (l2_mask_o !== 64'hF) begin miss++; $display("FAIL single_mask: got %h want f", l2_mask_o); end
    vec++; if (l2_data_o[31:0] !== 32'hDEADBEEF) begin miss++; $display("FAIL single_data: got %h want deadbeef", l2_data_o[31:0]); end
    drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
    vec++; if (store_complete_o !== 1'b0) begin miss++; $display("FAIL single_sc_early: got %0b want 0", store_complete_o); end
    cyc();
    idle();
    vec++; if (store_complete_o !== 1'b1) begin miss++; $display("FAIL single_sc: got %0b want 1", store_complete_o); end
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL single_req_off: got %0b want 0", l2_req_o); end
    cyc();
    vec++; if (store_complete_o !== 1'b0) begin miss++; $display("FAIL single_sc_pulse: got %0b want 0", store_complete_o); end
  endtask
  task automatic test_full;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b1, 32'(i * 64), 64'h1, 512'(i + 1), 1'b0);
      if (i == 3) begin
        vec++; if (full_o !== 1'b0) begin miss++; $display("FAIL full_early: got %0b want 0", full_o); end
      end
      if (i == 4) begin
        vec++; if (full_o !== 1'b1) begin miss++; $display("FAIL full_set: got %0b want 1", full_o); end
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
      vec++; if (l2_req_o !== 1'b1 || l2_address_o !== 26'(i)) begin miss++; $display("FAIL full_drain%0d: got req=%0b addr=%h want req=1 addr=%h", i, l2_req_o, l2_address_o, i); end
      vec++; if (l2_data_o[7:0] !== 8'(i + 1)) begin miss++; $display("FAIL full_data%0d: got %h want %h", i, l2_data_o[7:0], i + 1); end
      cyc();
    end
    idle();
    vec++; if (l2_req_o !== 1'b0 || full_o !== 1'b0) begin miss++; $display("FAIL full_empty: got req=%0b full=%0b want 0 0", l2_req_o, full_o); end
  endtask
  task automatic test_merge;
    do_reset();
    drv(1'b1, 1'b1, 32'h1000, 64'h1, 512'h55, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 32'h2000, 64'h00F, 512'h11111111, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 32'h2004, 64'h0F0, 512'h22222222_00000000, 1'b0);
    cyc();
    drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
    vec++; if (l2_address_o !== 26'h40 || l2_mask_o !== 64'h1) begin miss++; $display("FAIL merge_head: got addr=%h mask=%h want 40 1", l2_address_o, l2_mask_o); end
    cyc();
    vec++; if (l2_address_o !== 26'h80 || l2_mask_o !== 64'hFF) begin miss++; $display("FAIL merge_mask: got addr=%h mask=%h want 80 ff", l2_address_o, l2_mask_o); end
    vec++; if (l2_data_o[63:0] !== 64'h22222222_11111111) begin miss++; $display("FAIL merge_data: got %h want 2222222211111111", l2_data_o[63:0]); end
    cyc();
    idle();
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL merge_count: got req=%0b want 0", l2_req_o); end
  endtask
  task automatic test_head_block;
    do_reset();
    drv(1'b1, 1'b1, 32'h3000, 64'h1, 512'hAA, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 32'h3000, 64'h2, 512'hBB00, 1'b0);
    cyc();
    idle();
    vec++; if (l2_mask_o !== 64'h1 || l2_data_o[15:0] !== 16'h00AA) begin miss++; $display("FAIL head_stable: got mask=%h data=%h want 1 00aa", l2_mask_o, l2_data_o[15:0]); end
    drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
    cyc();
    vec++; if (l2_req_o !== 1'b1 || l2_address_o !== 26'hC0 || l2_mask_o !== 64'h2 || l2_data_o[15:0] !== 16'hBB00) begin miss++; $display("FAIL head_second: got req=%0b addr=%h mask=%h data=%h want 1 c0 2 bb00", l2_req_o, l2_address_o, l2_mask_o, l2_data_o[15:0]); end
    cyc();
    idle();
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL head_empty: got %0b want 0", l2_req_o); end
  endtask
  task automatic test_full_ack;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 32'h400 + 32'(i * 64), 64'h1, 512'h0, 1'b0);
      cyc();
    end
    drv(1'b1, 1'b1, 32'h500, 64'h1, 512'h0, 1'b1);
    vec++; if (full_o !== 1'b1) begin miss++; $display("FAIL fullack_pre: got %0b want 1", full_o); end
    cyc();
    idle();
    vec++; if (full_o !== 1'b0) begin miss++; $display("FAIL fullack_post: got %0b want 0", full_o); end
    for (int i = 1; i < 4; i++) begin
      drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
      vec++; if (l2_req_o !== 1'b1 || l2_address_o !== 26'h10 + 26'(i)) begin miss++; $display("FAIL fullack_drain%0d: got req=%0b addr=%h want 1 %h", i, l2_req_o, l2_address_o, 16 + i); end
      cyc();
    end
    idle();
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL fullack_rejected: got req=%0b want 0", l2_req_o); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    drv(1'b1, 1'b1, 32'h40, 64'h1, 512'h0, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 32'h80, 64'h1, 512'h0, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 32'h1C0, 64'h1, 512'h0, 1'b1);
    cyc();
    drv(1'b0, 1'b0, 32'h0, 64'h0, 512'h0, 1'b1);
    vec++; if (l2_address_o !== 26'h2) begin miss++; $display("FAIL enqack_head: got %h want 2", l2_address_o); end
    cyc();
    vec++; if (l2_req_o !== 1'b1 || l2_address_o !== 26'h7) begin miss++; $display("FAIL enqack_next: got req=%0b addr=%h want 1 7", l2_req_o, l2_address_o); end
    cyc();
    idle();
    vec++; if (l2_req_o !== 1'b0) begin miss++; $display("FAIL enqack_count: got req=%0b want 0", l2_req_o); end
  endtask
  task automatic test_load_match;
    do_reset();
    drv(1'b0, 1'b0, 32'h3020, 64'h0, 512'h0, 1'b0);
    drv(1'b1, 1'b0, 32'h3020, 64'h0, 512'h0, 1'b0);
    vec++; if (load_match_o !== 1'b0) begin miss++; $display("FAIL lm_empty: got %0b want 0", load_match_o); end
    drv(1'b1, 1'b1, 32'h3000, 64'h1, 512'h0, 1'b0);
    cyc();
    drv(1'b1, 1'b0, 32'h3020, 64'h0, 512'h0, 1'b0);
    vec++; if (load_match_o !== 1'b1) begin miss++; $display("FAIL lm_hit: got %0b want 1", load_match_o); end
    drv(1'b1, 1'b0, 32'h3040, 64'h0, 512'h0, 1'b0);
    vec++; if (load_match_o !== 1'b0) begin miss++; $display("FAIL lm_miss: got %0b want 0", load_match_o); end
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 32'h8000 + 32'(i * 64), 64'h1, 512'h0, 1'b0);
      cyc();
    end
    drv(1'b1, 1'b0, 32'h3020, 64'h0, 512'h0, 1'b0);
    vec++; if (full_o !== 1'b1 || l2_req_o !== 1'b1 || load_match_o !== 1'b1) begin miss++; $display("FAIL rst_pre: got full=%0b req=%0b lm=%0b want 1 1 1", full_o, l2_req_o, load_match_o); end
    reset = 1'b1;
    l2_ack_i = 1'b1;
    cyc();
    reset = 1'b0;
    l2_ack_i = 1'b0;
    #1;
    vec++; if (l2_req_o !== 1'b0 || full_o !== 1'b0 || load_match_o !== 1'b0 || store_complete_o !== 1'b0) begin miss++; $display("FAIL rst_mid: got req=%0b full=%0b lm=%0b sc=%0b want 0 0 0 0", l2_req_o, full_o, load_match_o, store_complete_o); end
    idle();
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_merge();
    test_head_block();
    test_full_ack();
    test_back_to_back();
    test_load_match();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
